neuron_accum: RTL and testbench

Sequential accumulate/activate stage that consumes the sign-magnitude products of the neuron multiplier, one product per beat. It sums one neuron's worth of products in a saturating two's-complement accumulator, adds the neuron bias, applies optional ReLU, and rescales the result back to the `bit`-wide sign-magnitude activation format. Each result is handed to the next layer over a valid/ready handshake.

---
 rtl/nn_pkg.sv | 46 ++++
 rtl/neuron_accum_if.sv | 24 ++
 rtl/sm_to_act.sv | 27 ++
 rtl/neuron_accum.sv | 125 ++++++++++++
 tb/tb_neuron_accum.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/nn_pkg.sv
// Shared neuron-datapath definitions: default widths, accumulator sizing, FSM states
// and sign-magnitude <-> two's-complement conversion helpers.
package nn_pkg;

    localparam int BITS_DEF  = 16;
    localparam int GUARD_DEF = 8;
    localparam int CONV_W    = 64;

    typedef enum logic [1:0] {ST_ACC, ST_BIAS, ST_OUT} state_t;

    function automatic int acc_w(input int bits, input int guard);
        return 2 * bits - 1 + guard;
    endfunction

    // w-bit sign-magnitude (zero-extended into sm) to two's complement; -0 maps to 0.
    function automatic logic signed [CONV_W-1:0] sm_to_tc(input logic [CONV_W-1:0] sm,
                                                         input int w);
        logic [CONV_W-1:0] sign_bit;
        logic [CONV_W-1:0] mag;
        sign_bit = CONV_W'(1) << (w - 1);
        mag      = sm & (sign_bit - CONV_W'(1));
        if (((sm & sign_bit) != '0) && (mag != '0)) begin
            return -$signed(mag);
        end
        return $signed(mag);
    endfunction

    // Two's complement to w-bit sign-magnitude, saturating the magnitude; zero is always +0.
    function automatic logic [CONV_W-1:0] tc_to_sm(input logic signed [CONV_W-1:0] v,
                                                   input int w);
        logic              neg;
        logic [CONV_W-1:0] mag;
        logic [CONV_W-1:0] max_mag;
        max_mag = (CONV_W'(1) << (w - 1)) - CONV_W'(1);
        neg     = (v < 0);
        mag     = neg ? -v : v;
        if (mag > max_mag) begin
            mag = max_mag;
        end
        if (mag == '0) begin
            neg = 1'b0;
        end
        return neg ? (mag | (CONV_W'(1) << (w - 1))) : mag;
    endfunction

endpackage

// File: rtl/neuron_accum_if.sv
// Product-in / activation-out handshake bundle of the neuron accumulate stage.
interface neuron_accum_if import nn_pkg::*; #(
    parameter int BITS = BITS_DEF
);
    logic [2*BITS-2:0] in_prod;
    logic              in_valid;
    logic              in_last;
    logic [BITS-1:0]   in_bias;
    logic              in_ready;
    logic [BITS-1:0]   out_act;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_count;

    modport master (
        output in_prod, in_valid, in_last, in_bias, out_ready,
        input  in_ready, out_act, out_valid, out_count
    );

    modport slave (
        input  in_prod, in_valid, in_last, in_bias, out_ready,
        output in_ready, out_act, out_valid, out_count
    );
endinterface

// File: rtl/sm_to_act.sv
// Accumulator to sign-magnitude activation: optional ReLU, rescale by 2^(BITS-1)
// truncating toward zero, and magnitude saturation.
module sm_to_act import nn_pkg::*; #(
    parameter int BITS  = BITS_DEF,
    parameter int ACC_W = acc_w(BITS_DEF, GUARD_DEF),
    parameter int RELU  = 1
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic        [BITS-1:0]  act
);
    logic signed [ACC_W-1:0]  r;
    logic        [ACC_W-1:0]  abs_r;
    logic        [ACC_W-1:0]  q;
    logic signed [CONV_W-1:0] q_tc;

    always_comb begin
        r = acc;
        if ((RELU != 0) && (r < 0)) begin
            r = '0;
        end
        // Unsigned view of -r is the exact magnitude even for the most negative code.
        abs_r = (r < 0) ? ACC_W'(-r) : ACC_W'(r);
        q     = abs_r >> (BITS - 1);
        q_tc  = (r < 0) ? -$signed(CONV_W'(q)) : $signed(CONV_W'(q));
        act   = BITS'(tc_to_sm(q_tc, BITS));
    end
endmodule

// File: rtl/neuron_accum.sv
// Accumulate/activate stage: saturating sum of one neuron's products, bias add,
// activation rescale, and valid/ready hand-off of the result.
module neuron_accum import nn_pkg::*; #(
    parameter int BITS  = BITS_DEF,
    parameter int GUARD = GUARD_DEF,
    parameter int RELU  = 1
) (
    input  logic           clk,
    input  logic           rst,
    neuron_accum_if.slave  bus
);
    localparam int ACC_W  = acc_w(BITS, GUARD);
    localparam int PROD_W = 2 * BITS - 1;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-2){1'b0}}, 1'b1};

    state_t                  state;
    state_t                  state_next;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] bias_ext;
    logic signed [ACC_W-1:0] addend;
    logic signed [ACC_W-1:0] acc_sum;
    logic        [7:0]       cnt;
    logic        [BITS-1:0]  bias_r;
    logic        [BITS-1:0]  act_next;
    logic        [BITS-1:0]  out_act_r;
    logic        [7:0]       out_count_r;

    // Symmetric clamp: overflow never wraps, it pins at +/- full scale.
    function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] a,
                                                        input logic signed [ACC_W-1:0] b);
        logic signed [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        if (s[ACC_W] != s[ACC_W-1]) begin
            return s[ACC_W] ? ACC_MIN : ACC_MAX;
        end
        return s[ACC_W-1:0];
    endfunction

    always_comb begin
        prod_ext = ACC_W'(sm_to_tc(CONV_W'(bus.in_prod), PROD_W));
        bias_ext = ACC_W'(sm_to_tc(CONV_W'(bias_r), BITS) <<< (BITS - 1));
        addend   = (state == ST_BIAS) ? bias_ext : prod_ext;
        acc_sum  = sat_add(acc, addend);
    end

    // In BIAS, acc_sum is already the biased total, so the activation registered on
    // entry to OUT comes straight from it.
    sm_to_act #(
        .BITS  (BITS),
        .ACC_W (ACC_W),
        .RELU  (RELU)
    ) u_sm_to_act (
        .acc (acc_sum),
        .act (act_next)
    );

    // NOTE: clocked state uses non-blocking assignments so every register samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_ACC;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: default assignment first so no path through the case leaves
    // state_next unassigned and infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_ACC:  if (bus.in_valid && bus.in_last) state_next = ST_BIAS;
            ST_BIAS: state_next = ST_OUT;
            ST_OUT:  if (bus.out_ready) state_next = ST_ACC;
            default: state_next = ST_ACC;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == ST_ACC);
        bus.out_valid = (state == ST_OUT);
    end

    assign bus.out_act   = out_act_r;
    assign bus.out_count = out_count_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc         <= '0;
            cnt         <= '0;
            bias_r      <= '0;
            out_act_r   <= '0;
            out_count_r <= '0;
        end else begin
            case (state)
                ST_ACC: begin
                    if (bus.in_valid) begin
                        acc <= acc_sum;
                        if (cnt != 8'hFF) begin
                            cnt <= cnt + 8'd1;
                        end
                        if (bus.in_last) begin
                            bias_r <= bus.in_bias;
                        end
                    end
                end
                ST_BIAS: begin
                    acc         <= acc_sum;
                    out_act_r   <= act_next;
                    out_count_r <= cnt;
                end
                ST_OUT: begin
                    if (bus.out_ready) begin
                        acc <= '0;
                        cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_neuron_accum.sv
// Directed bench: a RELU=1 and a RELU=0 instance run in lockstep on identical stimulus.
module tb_neuron_accum;

    localparam logic [30:0] P25  = 31'h1000_0000;
    localparam logic [30:0] N50  = 31'h6000_0000;
    localparam logic [30:0] P100 = 31'h3FFF_0001;

    logic        clk = 1'b0;
    logic        rst;
    logic [30:0] prod;
    logic        valid;
    logic        last;
    logic [15:0] bias;
    logic        oready;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    neuron_accum_if #(.BITS(16)) if_relu ();
    neuron_accum_if #(.BITS(16)) if_lin ();

    assign if_relu.in_prod   = prod;
    assign if_relu.in_valid  = valid;
    assign if_relu.in_last   = last;
    assign if_relu.in_bias   = bias;
    assign if_relu.out_ready = oready;
    assign if_lin.in_prod    = prod;
    assign if_lin.in_valid   = valid;
    assign if_lin.in_last    = last;
    assign if_lin.in_bias    = bias;
    assign if_lin.out_ready  = oready;

    neuron_accum #(.BITS(16), .GUARD(8), .RELU(1)) dut_relu (
        .clk (clk),
        .rst (rst),
        .bus (if_relu)
    );

    neuron_accum #(.BITS(16), .GUARD(8), .RELU(0)) dut_lin (
        .clk (clk),
        .rst (rst),
        .bus (if_lin)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    task automatic beat(input logic [30:0] p, input logic l, input logic [15:0] b);
        @(negedge clk);
        prod  = p;
        valid = 1'b1;
        last  = l;
        bias  = b;
    endtask

    // Walks the fixed BIAS -> OUT -> handshake sequence after the last beat and
    // returns raw observations; comparisons stay in the callers.
    task automatic collect(output logic bias_busy, output logic res_valid,
                           output logic [15:0] a_r, output logic [15:0] a_l,
                           output logic [7:0] c, output logic back_ready);
        @(negedge clk);
        valid     = 1'b0;
        last      = 1'b0;
        bias_busy = !if_relu.out_valid && !if_relu.in_ready;
        @(negedge clk);
        res_valid = if_relu.out_valid && if_lin.out_valid;
        a_r       = if_relu.out_act;
        a_l       = if_lin.out_act;
        c         = if_relu.out_count;
        oready    = 1'b1;
        @(negedge clk);
        oready     = 1'b0;
        back_ready = if_relu.in_ready && !if_relu.out_valid;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (if_relu.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", if_relu.in_ready); end
        total++; if (if_relu.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", if_relu.out_valid); end
        total++; if (if_relu.out_act !== 16'h0000) begin bad++; $display("FAIL reset_out_act got=%h want=0000", if_relu.out_act); end
        total++; if (if_relu.out_count !== 8'd0) begin bad++; $display("FAIL reset_out_count got=%0d want=0", if_relu.out_count); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic bb, rv, br; logic [15:0] ar, al; logic [7:0] c;
        beat(P25, 1'b0, 16'h0000);
        beat(P25, 1'b0, 16'h0000);
        beat(P25, 1'b1, 16'h0000);
        collect(bb, rv, ar, al, c, br);
        total++; if (bb !== 1'b1) begin bad++; $display("FAIL basic_bias_cycle got=%b want=1", bb); end
        total++; if (rv !== 1'b1) begin bad++; $display("FAIL basic_latency_valid got=%b want=1", rv); end
        total++; if (ar !== 16'h6000) begin bad++; $display("FAIL basic_act got=%h want=6000", ar); end
        total++; if (c !== 8'd3) begin bad++; $display("FAIL basic_count got=%0d want=3", c); end
        total++; if (br !== 1'b1) begin bad++; $display("FAIL basic_back_to_acc got=%b want=1", br); end
    endtask

    task automatic test_relu();
        logic bb, rv, br; logic [15:0] ar, al; logic [7:0] c;
        beat(P25, 1'b0, 16'h0000);
        beat(N50, 1'b1, 16'h0000);
        collect(bb, rv, ar, al, c, br);
        total++; if (ar !== 16'h0000) begin bad++; $display("FAIL relu_clamp got=%h want=0000", ar); end
        total++; if (al !== 16'hA000) begin bad++; $display("FAIL relu_off_signed got=%h want=a000", al); end
        total++; if (c !== 8'd2) begin bad++; $display("FAIL relu_count got=%0d want=2", c); end
    endtask

    task automatic test_bias_sign();
        logic bb, rv, br; logic [15:0] ar, al; logic [7:0] c;
        beat(P25, 1'b1, 16'hC000);
        collect(bb, rv, ar, al, c, br);
        total++; if (ar !== 16'h0000) begin bad++; $display("FAIL negbias_relu got=%h want=0000", ar); end
        total++; if (al !== 16'hA000) begin bad++; $display("FAIL negbias_linear got=%h want=a000", al); end
    endtask

    task automatic test_saturate();
        logic bb, rv, br; logic [15:0] ar, al; logic [7:0] c;
        for (int i = 0; i < 4; i++) beat(P100, (i == 3), 16'h7FFF);
        collect(bb, rv, ar, al, c, br);
        total++; if (ar !== 16'h7FFF) begin bad++; $display("FAIL sat_act got=%h want=7fff", ar); end
        total++; if (al !== 16'h7FFF) begin bad++; $display("FAIL sat_act_linear got=%h want=7fff", al); end
        total++; if (c !== 8'd4) begin bad++; $display("FAIL sat_count got=%0d want=4", c); end
    endtask

    task automatic test_single();
        logic bb, rv, br; logic [15:0] ar, al; logic [7:0] c;
        beat(31'h0, 1'b1, 16'h4000);
        collect(bb, rv, ar, al, c, br);
        total++; if (ar !== 16'h4000) begin bad++; $display("FAIL single_bias_act got=%h want=4000", ar); end
        total++; if (c !== 8'd1) begin bad++; $display("FAIL single_count got=%0d want=1", c); end
        beat(31'h0, 1'b1, 16'h8000);
        collect(bb, rv, ar, al, c, br);
        total++; if (ar !== 16'h0000) begin bad++; $display("FAIL negzero_bias got=%h want=0000", ar); end
        total++; if (al !== 16'h0000) begin bad++; $display("FAIL negzero_bias_linear got=%h want=0000", al); end
    endtask

    task automatic test_stall();
        logic bb, rv, br; logic [15:0] ar, al; logic [7:0] c;
        beat(P25, 1'b1, 16'h0000);
        @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        // Offer the next neuron's only beat while the result is stalled.
        prod  = P25;
        valid = 1'b1;
        last  = 1'b1;
        bias  = 16'h0000;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            total++; if (if_relu.out_valid !== 1'b1) begin bad++; $display("FAIL stall_valid[%0d] got=%b want=1", i, if_relu.out_valid); end
            total++; if (if_relu.out_act !== 16'h2000) begin bad++; $display("FAIL stall_act[%0d] got=%h want=2000", i, if_relu.out_act); end
            total++; if (if_relu.in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready[%0d] got=%b want=0", i, if_relu.in_ready); end
        end
        oready = 1'b1;
        @(negedge clk);
        oready = 1'b0;
        total++; if (if_relu.in_ready !== 1'b1) begin bad++; $display("FAIL stall_release_ready got=%b want=1", if_relu.in_ready); end
        collect(bb, rv, ar, al, c, br);
        total++; if (bb !== 1'b1) begin bad++; $display("FAIL stall_next_bias got=%b want=1", bb); end
        total++; if (ar !== 16'h2000) begin bad++; $display("FAIL stall_next_act got=%h want=2000", ar); end
        total++; if (c !== 8'd1) begin bad++; $display("FAIL stall_next_count got=%0d want=1", c); end
    endtask

    task automatic test_reset_mid();
        logic bb, rv, br; logic [15:0] ar, al; logic [7:0] c;
        beat(P25, 1'b0, 16'h0000);
        beat(P25, 1'b0, 16'h0000);
        @(negedge clk);
        valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        total++; if (if_relu.out_act !== 16'h0000) begin bad++; $display("FAIL midrst_act got=%h want=0000", if_relu.out_act); end
        total++; if (if_relu.in_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b want=1", if_relu.in_ready); end
        #1 rst = 1'b0;
        beat(P25, 1'b1, 16'h0000);
        collect(bb, rv, ar, al, c, br);
        total++; if (ar !== 16'h2000) begin bad++; $display("FAIL midrst_result got=%h want=2000", ar); end
        total++; if (c !== 8'd1) begin bad++; $display("FAIL midrst_count got=%0d want=1", c); end
    endtask

    task automatic test_count_sat();
        logic bb, rv, br; logic [15:0] ar, al; logic [7:0] c;
        for (int i = 0; i < 300; i++) beat(31'h0, (i == 299), 16'h0000);
        collect(bb, rv, ar, al, c, br);
        total++; if (c !== 8'd255) begin bad++; $display("FAIL count_saturate got=%0d want=255", c); end
        total++; if (ar !== 16'h0000) begin bad++; $display("FAIL count_sat_act got=%h want=0000", ar); end
    endtask

    initial begin
        rst    = 1'b1;
        prod   = '0;
        valid  = 1'b0;
        last   = 1'b0;
        bias   = '0;
        oready = 1'b0;
        test_reset();
        test_basic();
        test_relu();
        test_bias_sign();
        test_saturate();
        test_single();
        test_stall();
        test_reset_mid();
        test_count_sat();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
